// File: rtl/spi_frame_slave.sv
// SPI target for 64-bit {addr,data} frames, oversampled in the clk domain.
// Writes land in a small register bank; reads stream the addressed word back on sdo.
module spi_frame_slave #(
  parameter int IDX_BITS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                mosi,
  input  logic                csb,
  output logic                sdo,
  output logic                frame_valid,
  output logic                frame_rd,
  output logic [31:0]         frame_addr,
  output logic [31:0]         frame_data,
  output logic                frame_err,
  output logic [CNT_W-1:0]    frame_cnt,
  input  logic [IDX_BITS-1:0] dbg_idx,
  output logic [31:0]         dbg_data
);

  localparam int DEPTH = 2**IDX_BITS;
  localparam int ARM_W = $clog2(SYNC_STAGES+2);

  typedef enum logic [1:0] {S_ARM, S_IDLE, S_SHIFT, S_END} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_csb_sync;
  logic                   r_sclk_d, r_csb_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '1;
      r_csb_sync  <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b1;
      r_csb_d     <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], csb};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_csb_d     <= r_csb_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk_s, w_csb_s, w_mosi_s;
  logic w_sclk_rise, w_sclk_fall, w_csb_rise, w_csb_fall;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_csb_s     = r_csb_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_d;
  assign w_csb_rise  =  w_csb_s  & ~r_csb_d;
  assign w_csb_fall  = ~w_csb_s  &  r_csb_d;

  state_t           r_state;
  logic [ARM_W-1:0] r_arm_cnt;
  logic [31:0]      r_shift;
  logic [6:0]       r_bit_cnt;
  logic             r_cap;
  logic [31:0]      r_addr;
  logic             r_rd;
  logic [31:0]      r_shadow;
  logic [31:0]      r_bank [DEPTH];

  logic       w_rd_phase;
  logic [4:0] w_sdo_pos;

  // Data-phase bit positions 32..63 map to shadow bits 31..0.
  assign w_rd_phase = r_rd && (r_bit_cnt >= 7'd32) && (r_bit_cnt <= 7'd63);
  assign w_sdo_pos  = 5'd31 - r_bit_cnt[4:0];

  always_ff @(posedge clk) begin
    frame_valid <= 1'b0;
    frame_err   <= 1'b0;
    r_cap       <= 1'b0;
    dbg_data    <= r_bank[dbg_idx];
    if (rst) begin
      r_state    <= S_ARM;
      r_arm_cnt  <= '0;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_addr     <= '0;
      r_rd       <= 1'b0;
      r_shadow   <= '0;
      sdo        <= 1'b0;
      frame_rd   <= 1'b0;
      frame_addr <= '0;
      frame_data <= '0;
      frame_cnt  <= '0;
      dbg_data   <= '0;
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else begin
      case (r_state)
        // Synchronizers come out of reset preset to idle, so wait for them to
        // fill with real samples before trusting csb high.
        S_ARM: begin
          sdo <= 1'b0;
          if (r_arm_cnt != ARM_W'(SYNC_STAGES+1)) r_arm_cnt <= r_arm_cnt + ARM_W'(1);
          else if (w_csb_s && r_csb_d)            r_state   <= S_IDLE;
        end
        S_IDLE: begin
          sdo <= 1'b0;
          if (w_csb_fall) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rd      <= 1'b0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_csb_rise) begin
            sdo     <= 1'b0;
            r_state <= S_END;
          end else begin
            if (w_sclk_rise) begin
              r_shift <= {r_shift[30:0], w_mosi_s};
              if (r_bit_cnt != 7'd65) r_bit_cnt <= r_bit_cnt + 7'd1;
              r_cap <= (r_bit_cnt == 7'd31);
            end
            if (r_cap) begin
              r_addr <= r_shift;
              r_rd   <= r_shift[31];
              if (r_shift[31]) r_shadow <= r_bank[r_shift[IDX_BITS-1:0]];
            end
            if (!w_rd_phase)      sdo <= 1'b0;
            else if (w_sclk_fall) sdo <= r_shadow[w_sdo_pos];
          end
        end
        S_END: begin
          sdo <= 1'b0;
          if (r_bit_cnt == 7'd64) begin
            frame_valid <= 1'b1;
            frame_rd    <= r_rd;
            frame_addr  <= r_addr;
            frame_data  <= r_rd ? r_shadow : r_shift;
            frame_cnt   <= frame_cnt + CNT_W'(1);
            if (!r_rd) r_bank[r_addr[IDX_BITS-1:0]] <= r_shift;
          end else begin
            frame_err <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: drives SPI frames as the master would and scores
// frame_valid/frame_err pulses, sdo read-back and the register bank.
module tb_spi_frame_slave;
  localparam int IDX_BITS = 4;
  localparam int SS       = 2;
  localparam int CNT_W    = 4;
  localparam int HP       = 8;

  logic clk, rst, sclk, mosi, csb;
  logic sdo, frame_valid, frame_rd, frame_err;
  logic [31:0] frame_addr, frame_data, dbg_data;
  logic [CNT_W-1:0] frame_cnt;
  logic [IDX_BITS-1:0] dbg_idx;

  spi_frame_slave #(.IDX_BITS(IDX_BITS), .SYNC_STAGES(SS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .csb(csb), .sdo(sdo),
    .frame_valid(frame_valid), .frame_rd(frame_rd), .frame_addr(frame_addr),
    .frame_data(frame_data), .frame_err(frame_err), .frame_cnt(frame_cnt),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic             err;
    logic             rd;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          nbits;
    logic        exp_err;
    logic        exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  logic [31:0]      m_bank [16];
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected no pulse", frame_valid, frame_err);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pulse_err", {31'd0, frame_err}, {31'd0, mon_e.err});
        chk("pulse_valid", {31'd0, frame_valid}, {31'd0, ~mon_e.err});
        if (!mon_e.err) begin
          chk("frame_rd", {31'd0, frame_rd}, {31'd0, mon_e.rd});
          chk("frame_addr", frame_addr, mon_e.addr);
          chk("frame_data", frame_data, mon_e.data);
          chk("frame_cnt", 32'(frame_cnt), 32'(mon_e.cnt));
        end
      end
    end
  end

  task automatic push_exp(input logic err, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data);
    exp_t e;
    e.err = err; e.rd = rd; e.addr = addr; e.data = data;
    if (!err) begin
      m_cnt = m_cnt + 1'b1;
      if (!rd) m_bank[addr[3:0]] = data;
    end
    e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic spi_bit(input logic b, output logic s);
    sclk = 1'b0;
    mosi = b;
    repeat (HP) @(negedge clk);
    s = sdo;
    sclk = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] addr, input logic [31:0] data,
                           input int nbits, output logic [31:0] sw);
    logic [63:0] fr;
    logic s;
    fr = {addr, data};
    sw = '0;
    @(negedge clk);
    csb = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit((i < 64) ? fr[63-i] : 1'b0, s);
      if (i >= 32 && i < 64) sw[63-i] = s;
    end
    repeat (HP) @(negedge clk);
    csb = 1'b1;
    mosi = 1'b0;
    repeat (2*HP) @(negedge clk);
  endtask

  task automatic drain(input string nm);
    for (int c = 0; c < 40 && sb_q.size() != 0; c++) @(negedge clk);
    chk(nm, 32'(sb_q.size()), 32'd0);
  endtask

  // Frame whose expectation comes from the bench's bank/counter model.
  task automatic model_frame(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] exp_d, sw;
    exp_d = addr[31] ? m_bank[addr[3:0]] : data;
    push_exp(1'b0, addr[31], addr, exp_d);
    run_frame(addr, data, 64, sw);
    drain("model_drain");
    if (addr[31]) chk("model_sdo_word", sw, exp_d);
  endtask

  task automatic sweep_bank(input string nm);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      dbg_idx = 4'(k);
      repeat (2) @(negedge clk);
      chk(nm, dbg_data, m_bank[k]);
    end
  endtask

  vec_t        vt [9];
  logic [31:0] sw;
  logic        s;
  logic [63:0] fr;

  initial begin
    vt[0] = '{32'h43C0_3100, 32'h2CCC_1122, 64, 1'b0, 1'b0, 32'h2CCC_1122};
    vt[1] = '{32'h8025_1122, 32'h08CC_1122, 64, 1'b0, 1'b1, 32'h0000_0000};
    vt[2] = '{32'h0025_1122, 32'h08CC_1122, 64, 1'b0, 1'b0, 32'h08CC_1122};
    vt[3] = '{32'h8000_0002, 32'hDEAD_BEEF, 64, 1'b0, 1'b1, 32'h08CC_1122};
    vt[4] = '{32'h0000_0005, 32'h1234_5678, 40, 1'b1, 1'b0, 32'h0000_0000};
    vt[5] = '{32'h0000_0005, 32'h1234_5678, 64, 1'b0, 1'b0, 32'h1234_5678};
    vt[6] = '{32'h0000_0007, 32'hAAAA_5555, 66, 1'b1, 1'b0, 32'h0000_0000};
    vt[7] = '{32'h8000_0005, 32'h0000_0000, 64, 1'b0, 1'b1, 32'h1234_5678};
    vt[8] = '{32'h8000_0007, 32'h0000_0000, 64, 1'b0, 1'b1, 32'h0000_0000};

    for (int k = 0; k < 16; k++) m_bank[k] = '0;
    m_cnt = '0;
    rst = 1'b1; sclk = 1'b1; mosi = 1'b0; csb = 1'b1; dbg_idx = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sdo", {31'd0, sdo}, 32'd0);
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_rd", {31'd0, frame_rd}, 32'd0);
    chk("rst_addr", frame_addr, 32'd0);
    chk("rst_data", frame_data, 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_dbg", dbg_data, 32'd0);
    repeat (10) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      push_exp(vt[i].exp_err, vt[i].exp_rd, vt[i].addr, vt[i].exp_data);
      run_frame(vt[i].addr, vt[i].data, vt[i].nbits, sw);
      drain("vec_drain");
      if (vt[i].exp_rd && !vt[i].exp_err) chk("vec_sdo_word", sw, vt[i].exp_data);
    end
    chk("cnt_after_table", 32'(frame_cnt), 32'd7);
    sweep_bank("bank_after_table");

    // Reset at bit 20 with csb still low: the tail of that frame must be ignored.
    fr = {32'h0000_0009, 32'h5A5A_5A5A};
    @(negedge clk);
    csb = 1'b0;
    repeat (HP) @(negedge clk);
    for (int i = 0; i < 20; i++) spi_bit(fr[63-i], s);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) m_bank[k] = '0;
    m_cnt = '0;
    @(negedge clk);
    chk("midrst_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst_addr", frame_addr, 32'd0);
    for (int i = 20; i < 64; i++) spi_bit(fr[63-i], s);
    repeat (HP) @(negedge clk);
    csb = 1'b1;
    repeat (4*HP) @(negedge clk);
    chk("midrst_quiet", 32'(sb_q.size()), 32'd0);
    sweep_bank("bank_after_midrst");

    // 17 valid frames from a zero count: a 4-bit counter wraps to 1.
    for (int k = 0; k < 16; k++) model_frame(32'(k) | 32'h0100_0000, $urandom);
    model_frame(32'h8000_0003, 32'h0);
    chk("cnt_wrap", 32'(frame_cnt), 32'd1);
    sweep_bank("bank_final");
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
